// File: rtl/lsu_subword_rmw.sv
// Load/store unit bridging byte/halfword/word core accesses onto a word-only data memory.
// Sub-word stores are performed as read-modify-write; loads are lane-selected and extended.
module lsu_subword_rmw #(
    parameter int MEM_WORDS = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_reg;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] merged_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic        err_q;

    logic        funct_ok;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] merged_rmw;

    always_comb begin
        funct_ok = 1'b0;
        if (req_we)
            funct_ok = req_funct3 inside {3'b000, 3'b001, 3'b010};
        else
            funct_ok = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = req_addr[31:2] >= WORD_LIMIT;
        req_err      = !funct_ok || misaligned || out_of_range;
    end

    always_comb begin
        byte_sel  = mem_rd[{addr_q[1:0], 3'b000} +: 8];
        half_sel  = mem_rd[{addr_q[1], 4'b0000} +: 16];
        load_data = mem_rd;
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = mem_rd;
        endcase
    end

    // Per-byte merge: a lane takes store data when it falls inside the addressed byte/halfword.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic       hit;
            logic [7:0] store_byte;
            assign hit        = funct3_q[0] ? (addr_q[1] == 1'(gi / 2))
                                            : (addr_q[1:0] == 2'(gi));
            assign store_byte = funct3_q[0] ? wdata_q[8*(gi%2) +: 8] : wdata_q[7:0];
            assign merged_rmw[8*gi +: 8] = hit ? store_byte : mem_rd[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            merged_q  <= '0;
            funct3_q  <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        funct3_q <= req_funct3;
                        we_q     <= req_we;
                        merged_q <= req_wdata;
                        rdata_q  <= '0;
                        err_q    <= req_err;
                        if (req_err)
                            state_reg <= RESP;
                        else if (req_we && (req_funct3[1:0] == 2'b10))
                            state_reg <= WRITE;
                        else
                            state_reg <= READ;
                    end
                end
                READ: begin
                    if (we_q) begin
                        merged_q  <= merged_rmw;
                        state_reg <= WRITE;
                    end else begin
                        rdata_q   <= load_data;
                        state_reg <= RESP;
                    end
                end
                WRITE:   state_reg <= RESP;
                RESP:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from the state register only, so reset takes effect immediately.
    assign req_ready  = (state_reg == IDLE);
    assign mem_we     = (state_reg == WRITE);
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_wd     = merged_q;
    assign mem_addr   = {2'b00, addr_q[31:2]};

endmodule

// File: doc/lsu_subword_rmw.md
Name: lsu_subword_rmw

Overview:
- Load/store unit between the core datapath and the word-only data memory (32-bit WE/address/WD/RD, combinational read, word-indexed address).
- Converts byte, halfword and word loads and stores into word accesses: sign/zero extension for loads, read-modify-write for sub-word stores.
- Flags misaligned and out-of-range accesses.
- Core side uses a valid/ready request and a one-cycle response pulse.

Parameters:
- MEM_WORDS, 100, number of 32-bit words in the attached data memory; valid word indices are 0..MEM_WORDS-1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents an access.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  access rejected; valid with resp_valid.
- mem_we  out  1  to data memory WE.
- mem_addr  out  32  to data memory address = {2'b00, addr_q[31:2]}.
- mem_wd  out  32  to data memory WD.
- mem_rd  in  32  from data memory RD (combinational).

Behaviour:
- Reset (async, rst=0):
  - State returns to IDLE and all internal registers clear to 0.
  - resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0 immediately.
  - A reset in any state aborts the access with no response. A reset in WRITE deasserts mem_we before the next edge, so no write commits.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, latch addr_q, wdata_q, funct3_q and we_q, then classify:
    - Error if funct3 is illegal (load 011/110/111; store anything except 000/001/010).
    - Error if misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0).
    - Error if out of range (addr[31:2] >= MEM_WORDS).
  - Next state:
    - error -> RESP with err_q=1 and no memory access.
    - load -> READ.
    - SW -> WRITE with merged_q=wdata.
    - SB or SH -> READ.
- READ:
  - mem_addr is driven from addr_q; mem_rd is sampled at the edge.
  - Load: rdata_q = selected lane, extended, then -> RESP.
    - Byte lane is addr_q[1:0]; halfword lane is addr_q[1].
    - B/H sign-extend; BU/HU zero-extend; W passes through.
  - SB: merged_q = mem_rd with byte lane addr_q[1:0] replaced by wdata_q[7:0], then -> WRITE.
  - SH: merged_q = mem_rd with halfword lane addr_q[1] replaced by wdata_q[15:0], then -> WRITE.
- WRITE: mem_we=1 and mem_wd=merged_q for exactly one cycle; the write commits at the edge; then -> RESP.
- RESP: resp_valid=1 for one cycle with resp_rdata=rdata_q and resp_err=err_q, then -> IDLE. There is no response backpressure.
- Latency from the accepting edge to the resp_valid cycle:
  - error: 1 cycle.
  - load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
- req_ready=0 outside IDLE, and req_valid is ignored there. A new request can be accepted on the edge that leaves RESP only in the next IDLE cycle, giving back-to-back throughput of one access per latency+1 cycles.
- Outside WRITE: mem_we=0 and mem_wd=merged_q. mem_addr always reflects addr_q.
- Outputs are registered or state-decoded; there is no combinational path from req_* to mem_* or resp_*.

Test Plan:
- Reset with no traffic -> resp_valid=0, mem_we=0, req_ready=1, resp_rdata=0.
- SW addr=0x08 wdata=0xDEADBEEF -> mem_we high 1 cycle with mem_addr=2, mem_wd=0xDEADBEEF; resp_valid 2 cycles after accept with err=0. Then LW addr=0x08 -> resp_rdata=0xDEADBEEF.
- Word 2 holding 0xDEADBEEF, SB addr=0x09 wdata=0x12 -> mem_wd=0xDEAD12EF; resp 3 cycles after accept. Then LB addr=0x09 -> 0x00000012; LBU addr=0x0B -> 0x000000DE; LB addr=0x0B -> 0xFFFFFFDE.
- Word 2 holding 0xDEAD12EF, SH addr=0x0A wdata=0x8001 -> word 2 = 0x800112EF. Then LH addr=0x0A -> 0xFFFF8001; LHU addr=0x0A -> 0x00008001.
- Misaligned and illegal requests:
  - LW addr=0x06 -> resp_err=1, 1-cycle latency, mem_we never asserted.
  - SH addr=0x03 -> err=1.
  - Store funct3=100 -> err=1.
  - SW addr=4*MEM_WORDS (0x190) -> err=1, no write.
- Assert rst=0 during WRITE of an SB -> mem_we drops immediately, the target word keeps its pre-store value, no resp_valid, and req_ready=1 after reset release.
